// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer with synchronous flush; pointers wrap modulo DEPTH.
module fetch_fifo #(
  parameter int unsigned width = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [width-1:0]  i_wdata,
  output logic [width-1:0]  o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [CntW-1:0]   o_count
);

  logic [width-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PtrW-1:0]  w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CntW-1:0]  r_count;
  logic             w_do_push, w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Explicit wrap so non-power-of-two depths stay in range.
  assign w_wr_ptr_nxt = (r_wr_ptr == PtrW'(DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PtrW'(DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_do_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues memory requests, buffers returned words and handles
// branch redirects, discarding words from requests issued before the redirect.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     bus      = 32,
  parameter logic [bus-1:0]  RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [bus-1:0]  o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_instruction,
  output logic [bus-1:0]  o_pci,
  output logic            o_instr_valid,
  input  logic            i_dec_ready,
  input  logic            i_branch_take,
  input  logic [bus-1:0]  i_branch_target
);

  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned EntryW = 32 + bus;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  fetch_state_e      r_state, w_state_nxt;
  logic [bus-1:0]    r_fetch_pc, w_fetch_pc_nxt;
  logic [bus-1:0]    r_req_addr, w_req_addr_nxt;
  logic              w_push, w_pop;
  logic              w_full, w_empty;
  logic [CntW-1:0]   w_count, w_count_after_pop, w_count_post;
  logic [EntryW-1:0] w_head;

  // Branch overrides push/pop; the fifo flush carries the redirect.
  assign w_pop  = ~w_empty & i_dec_ready & ~i_branch_take;
  assign w_push = (r_state == BUSY) & i_imem_ack & ~i_branch_take & ~w_full;

  assign w_count_after_pop = w_count - CntW'(w_pop);
  assign w_count_post      = w_count_after_pop + CntW'(w_push);

  fetch_fifo #(
    .width (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_branch_take),
    .i_wdata ({i_imem_rdata, r_fetch_pc}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_branch_take || (w_count_after_pop < DepthC)) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (i_branch_take) begin
          w_state_nxt = i_imem_ack ? BUSY : DROP;
        end else if (i_imem_ack) begin
          w_state_nxt = (w_count_post < DepthC) ? BUSY : IDLE;
        end
      end
      DROP: begin
        if (i_imem_ack) w_state_nxt = BUSY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (i_branch_take) begin
      w_fetch_pc_nxt = i_branch_target;
    end else if (w_push) begin
      w_fetch_pc_nxt = r_fetch_pc + bus'(PC_STEP);
    end
    // Freezes the in-flight address once a redirect turns it into a dropped request.
    w_req_addr_nxt = (r_state == DROP) ? r_req_addr : r_fetch_pc;
  end

  always_comb begin
    o_imem_req    = (r_state != IDLE);
    o_imem_addr   = (r_state == DROP) ? r_req_addr : r_fetch_pc;
    o_instr_valid = ~w_empty;
    o_instruction = w_empty ? 32'h0 : w_head[EntryW-1 -: 32];
    o_pci         = w_empty ? '0 : w_head[bus-1:0];
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (bus=32, DEPTH=2, RESET_PC=0).
module tb_instruction_fetch;

  localparam int unsigned Bus   = 32;
  localparam int unsigned Depth = 2;
  localparam logic [31:0] ResetPc = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pci;
  logic        instr_valid;
  logic        dec_ready;
  logic        branch_take;
  logic [31:0] branch_target;

  int unsigned n_checks;
  int unsigned n_fails;

  instruction_fetch #(
    .bus      (Bus),
    .RESET_PC (ResetPc),
    .DEPTH    (Depth)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_ack      (imem_ack),
    .i_imem_rdata    (imem_rdata),
    .o_instruction   (instruction),
    .o_pci           (pci),
    .o_instr_valid   (instr_valid),
    .i_dec_ready     (dec_ready),
    .i_branch_take   (branch_take),
    .i_branch_target (branch_target)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory stub: returns a word derived from the requested address.
  assign imem_rdata = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 64'(instr_valid), 64'(1));
    check_eq({tag, "_pci"}, 64'(pci), 64'(pc));
    check_eq({tag, "_instr"}, 64'(instruction), 64'(mem_word(pc)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dec_ready = 1'b0;
    branch_take = 1'b0;
    branch_target = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // Reset state, with a stray ack that must be ignored
    rst_n = 1'b0;
    imem_ack = 1'b1;
    dec_ready = 1'b0;
    branch_take = 1'b0;
    branch_target = '0;
    #3;
    check_eq("rst_req", 64'(imem_req), 64'(0));
    check_eq("rst_valid", 64'(instr_valid), 64'(0));
    check_eq("rst_instr", 64'(instruction), 64'(0));
    check_eq("rst_pci", 64'(pci), 64'(0));
    check_eq("rst_addr", 64'(imem_addr), 64'(ResetPc));
    step();
    step();
    check_eq("rst_req_held", 64'(imem_req), 64'(0));

    // Streaming: ack every request, decoder always ready
    rst_n = 1'b1;
    imem_ack = 1'b1;
    dec_ready = 1'b1;
    step();
    check_eq("first_req", 64'(imem_req), 64'(1));
    check_eq("first_addr", 64'(imem_addr), 64'(0));
    check_eq("first_valid", 64'(instr_valid), 64'(0));
    step();
    for (int k = 0; k < 4; k++) begin
      check_head("stream", 32'(4 * k));
      step();
    end

    // Backpressure fills the buffer, then one pop reissues at 0x8
    do_reset();
    imem_ack = 1'b1;
    dec_ready = 1'b0;
    step();
    step();
    check_head("bp_first", 32'h0);
    step();
    check_eq("bp_full_req", 64'(imem_req), 64'(0));
    check_head("bp_full", 32'h0);
    step();
    check_eq("bp_idle_req", 64'(imem_req), 64'(0));
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check_eq("bp_reissue_req", 64'(imem_req), 64'(1));
    check_eq("bp_reissue_addr", 64'(imem_addr), 64'h8);
    check_head("bp_after_pop", 32'h4);
    step();
    check_eq("bp_refull_req", 64'(imem_req), 64'(0));
    check_head("bp_refull", 32'h4);

    // Branch while a request is waiting: DROP, stale word discarded
    do_reset();
    imem_ack = 1'b1;
    dec_ready = 1'b1;
    repeat (5) step();
    check_eq("drop_pre_addr", 64'(imem_addr), 64'h10);
    check_head("drop_pre", 32'hC);
    imem_ack = 1'b0;
    branch_take = 1'b1;
    branch_target = 32'h100;
    step();
    branch_take = 1'b0;
    check_eq("drop_req", 64'(imem_req), 64'(1));
    check_eq("drop_addr", 64'(imem_addr), 64'h10);
    check_eq("drop_flushed", 64'(instr_valid), 64'(0));
    step();
    check_eq("drop_addr_hold", 64'(imem_addr), 64'h10);
    step();
    imem_ack = 1'b1;
    step();
    check_eq("drop_reissue_addr", 64'(imem_addr), 64'h100);
    check_eq("drop_discarded", 64'(instr_valid), 64'(0));
    step();
    check_head("drop_target", 32'h100);

    // Branch with full buffer, ignored ack and pop in the same cycle
    do_reset();
    imem_ack = 1'b1;
    dec_ready = 1'b0;
    repeat (3) step();
    check_eq("flush_pre_req", 64'(imem_req), 64'(0));
    dec_ready = 1'b1;
    branch_take = 1'b1;
    branch_target = 32'h40;
    step();
    branch_take = 1'b0;
    check_eq("flush_valid", 64'(instr_valid), 64'(0));
    check_eq("flush_instr", 64'(instruction), 64'(0));
    check_eq("flush_pci", 64'(pci), 64'(0));
    check_eq("flush_req", 64'(imem_req), 64'(1));
    check_eq("flush_addr", 64'(imem_addr), 64'h40);
    step();
    check_head("flush_target", 32'h40);

    // Unaligned target with ack in the branch cycle
    branch_take = 1'b1;
    branch_target = 32'h102;
    step();
    branch_take = 1'b0;
    check_eq("unal_addr", 64'(imem_addr), 64'h102);
    check_eq("unal_valid", 64'(instr_valid), 64'(0));
    step();
    check_head("unal", 32'h102);
    check_eq("unal_next_addr", 64'(imem_addr), 64'h106);

    // Asynchronous reset mid-BUSY with an ack during reset
    do_reset();
    imem_ack = 1'b1;
    dec_ready = 1'b1;
    repeat (3) step();
    check_eq("mid_pre_addr", 64'(imem_addr), 64'h8);
    imem_ack = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 64'(imem_req), 64'(0));
    check_eq("mid_rst_valid", 64'(instr_valid), 64'(0));
    check_eq("mid_rst_instr", 64'(instruction), 64'(0));
    check_eq("mid_rst_pci", 64'(pci), 64'(0));
    check_eq("mid_rst_addr", 64'(imem_addr), 64'(ResetPc));
    imem_ack = 1'b1;
    step();
    step();
    check_eq("mid_late_ack_req", 64'(imem_req), 64'(0));
    check_eq("mid_late_ack_valid", 64'(instr_valid), 64'(0));
    imem_ack = 1'b0;
    rst_n = 1'b1;
    step();
    check_eq("mid_post_req", 64'(imem_req), 64'(1));
    check_eq("mid_post_addr", 64'(imem_addr), 64'(ResetPc));

    // PC wraps past the top of the address space
    imem_ack = 1'b1;
    branch_take = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_take = 1'b0;
    check_eq("wrap_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    step();
    check_eq("wrap_next_addr", 64'(imem_addr), 64'h0);
    check_head("wrap", 32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter bus, default 32: datapath and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter DEPTH, default 2: fetch buffer entries (2..4).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  instruction memory request, level, held until acknowledged.
REQ-007 imem_addr  out  bus  byte address of the pending request, stable while imem_req=1.
REQ-008 imem_ack  in  1  memory accepts and returns data in the same cycle; ignored when imem_req=0.
REQ-009 imem_rdata  in  32  instruction word, valid when imem_req=1 and imem_ack=1.
REQ-010 instruction  out  32  instruction word for the decoder; 32'h0 when instr_valid=0.
REQ-011 PCi  out  bus  address of the presented instruction; 0 when instr_valid=0.
REQ-012 instr_valid  out  1  buffer head holds a valid instruction.
REQ-013 dec_ready  in  1  decoder consumes the head this cycle.
REQ-014 branch_take  in  1  redirect request from branch writeback.
REQ-015 branch_target  in  bus  redirect address.

Function
REQ-016 The block SHALL implement FSM states IDLE (no request outstanding), BUSY (request outstanding, data kept), DROP (request outstanding, data discarded).
REQ-017 imem_req SHALL be 1 exactly in BUSY and DROP, driven from registered state.
REQ-018 imem_addr SHALL equal the registered fetch PC in BUSY and the address captured at request issue in DROP.
REQ-019 IDLE->BUSY SHALL occur when buffer count < DEPTH, counting the same-cycle pop.
REQ-020 In BUSY with imem_ack=1: push {imem_rdata, fetch PC}, fetch PC += 4; remain BUSY if post-update count < DEPTH, else IDLE.
REQ-021 Pop SHALL occur when instr_valid=1 and dec_ready=1; push and pop in one cycle SHALL leave count unchanged.
REQ-022 Buffer SHALL be in-order FIFO; pointers wrap modulo DEPTH; never push when full, never pop when empty.
REQ-023 branch_take=1 SHALL, in that cycle's update: flush buffer (count 0), fetch PC = branch_target, override any push/pop.
REQ-024 branch_take in BUSY with imem_ack=0 SHALL go DROP; with imem_ack=1 the returning word is discarded and next state is BUSY.
REQ-025 branch_take in IDLE SHALL go BUSY; in DROP SHALL stay DROP (or BUSY if imem_ack=1).
REQ-026 In DROP with imem_ack=1 data SHALL be discarded and next state BUSY.
REQ-027 Latency: ack in cycle N makes instruction visible with instr_valid=1 in cycle N+1.
REQ-028 branch_target SHALL be used unaligned as given; PC increment wraps modulo 2^bus.

Reset
REQ-029 On rst=0, asynchronously: state IDLE, fetch PC=RESET_PC, count 0, pointers 0, imem_req=0, instr_valid=0, instruction=0, PCi=0.
REQ-030 Reset during BUSY/DROP SHALL abandon the request; a late imem_ack after reset SHALL be ignored (imem_req=0).
REQ-031 First imem_req SHALL assert in the first clock edge after rst deasserts.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the state enum (IDLE, BUSY, DROP) and constant PC_STEP=4.
REQ-033 Buffer SHALL be sub-module fetch_fifo (parameters width, DEPTH; push, pop, flush, full, empty, count).
REQ-034 No combinational path from imem_ack/imem_rdata to imem_req or instruction.

Verification
REQ-035 Reset release, ack every request, dec_ready=1 -> PCi sequence 0,4,8,12 on consecutive cycles after 2-cycle startup.
REQ-036 dec_ready=0, acks always -> exactly DEPTH=2 words buffered, imem_req drops to 0; dec_ready=1 one cycle -> one pop, request reissued at 0x8.
REQ-037 BUSY at 0x10, ack delayed 3 cycles, branch_take target 0x100 in cycle 1 -> DROP, delayed word discarded, next request addr 0x100, first PCi 0x100.
REQ-038 branch_take 0x40 same cycle as ack and pop with 2 entries buffered -> buffer empty, instr_valid=0 next cycle, imem_addr=0x40.
REQ-039 rst asserted mid-BUSY with ack arriving during reset -> all outputs 0, first post-reset imem_addr=RESET_PC.
REQ-040 Fetch PC 32'hFFFF_FFFC acked -> next imem_addr 32'h0000_0000.
